// File: rtl/recirc_cdc_tx_sched_if.sv
// Handshake bundle between the recirculation CDC scheduler and its requesters / clk2 receiver.
// master = scheduler side, slave = requesters plus receiver side.
interface recirc_cdc_tx_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         cdc_data;
    logic [ID_W-1:0]           cdc_id;
    logic                      cdc_en;
    logic                      cdc_ack_async;
    logic                      busy;
    logic                      timeout_err;
    logic                      err_clr;

    modport master (
        input  req, req_data, cdc_ack_async, err_clr,
        output gnt, cdc_data, cdc_id, cdc_en, busy, timeout_err
    );

    modport slave (
        output req, req_data, cdc_ack_async, err_clr,
        input  gnt, cdc_data, cdc_id, cdc_en, busy, timeout_err
    );
endinterface

// File: rtl/recirc_cdc_tx_sched.sv
// Source-side (clk1) round-robin scheduler driving a 4-phase enable/ack CDC channel.
// Grant one edge after req; cdc_en one edge later; a stuck or dead receiver is aborted by timeout.
module recirc_cdc_tx_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk1,
    input  logic                  rst_clk1,
    recirc_cdc_tx_sched_if.master bus
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_REQ, S_DROP} state_t;

    state_t             state, state_nxt;
    logic               ack_meta, ack_s;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]   to_cnt, to_cnt_nxt;
    logic               to_fire;
    logic               grant;

    logic               win_vld, hi_vld;
    logic [ID_W-1:0]    win_idx, hi_idx, lo_idx;
    logic [DATA_W-1:0]  win_data;

    logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
    logic [DATA_W-1:0]  data_q, data_nxt;
    logic [ID_W-1:0]    id_q, id_nxt;
    logic               en_q, en_nxt;
    logic               busy_q, busy_nxt;
    logic               err_q, err_nxt;

    // Receiver ack is a level from clk2; only the synchronized copy is used.
    always_ff @(posedge clk1 or posedge rst_clk1) begin
        if (rst_clk1) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= bus.cdc_ack_async;
            ack_s    <= ack_meta;
        end
    end

    // Descending scan: the last hit is the lowest index, overall and at/after rr_ptr.
    always_comb begin
        hi_vld  = 1'b0;
        hi_idx  = '0;
        win_vld = 1'b0;
        lo_idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                win_vld = 1'b1;
                lo_idx  = ID_W'(i);
                if (i >= int'(rr_ptr)) begin
                    hi_vld = 1'b1;
                    hi_idx = ID_W'(i);
                end
            end
        end
        win_idx = hi_vld ? hi_idx : lo_idx;
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                win_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        to_fire = 1'b0;
        if (TIMEOUT != 0 && to_cnt == CNT_W'(TIMEOUT - 1)) begin
            if ((state == S_REQ && !ack_s) || (state == S_DROP && ack_s)) begin
                to_fire = 1'b1;
            end
        end
    end

    assign grant = (state == S_IDLE) && win_vld && !ack_s;

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant) state_nxt = S_SETUP;
            S_SETUP: state_nxt = S_REQ;
            S_REQ: begin
                if (ack_s)        state_nxt = S_DROP;
                else if (to_fire) state_nxt = S_IDLE;
            end
            S_DROP:  if (!ack_s || to_fire) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values; everything visible is registered below.
    always_comb begin
        gnt_nxt    = '0;
        data_nxt   = data_q;
        id_nxt     = id_q;
        rr_ptr_nxt = rr_ptr;
        if (grant) begin
            gnt_nxt    = NUM_REQ'(1) << win_idx;
            data_nxt   = win_data;
            id_nxt     = win_idx;
            rr_ptr_nxt = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
        end
        en_nxt   = (state_nxt == S_REQ);
        busy_nxt = (state_nxt != S_IDLE);
        err_nxt  = to_fire ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
        if (state_nxt != state) begin
            to_cnt_nxt = '0;
        end else if (state == S_REQ || state == S_DROP) begin
            to_cnt_nxt = to_cnt + CNT_W'(1);
        end else begin
            to_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk1 or posedge rst_clk1) begin
        if (rst_clk1) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            to_cnt <= '0;
            gnt_q  <= '0;
            data_q <= '0;
            id_q   <= '0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            to_cnt <= to_cnt_nxt;
            gnt_q  <= gnt_nxt;
            data_q <= data_nxt;
            id_q   <= id_nxt;
            en_q   <= en_nxt;
            busy_q <= busy_nxt;
            err_q  <= err_nxt;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.cdc_data    = data_q;
    assign bus.cdc_id      = id_q;
    assign bus.cdc_en      = en_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_recirc_cdc_tx_sched.sv
// Directed bench for recirc_cdc_tx_sched: grant scoreboard, clk2 ack echo model, timeout and reset cases.
`timescale 1ns/1ps
module tb_recirc_cdc_tx_sched;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk1 = 1'b0;
    logic clk2 = 1'b0;
    logic rst_clk1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic prev_busy = 1'b0;
    logic [2:0] ack_sh = '0;
    int   ack_mode = 0;   // 0 echo, 1 stuck low, 2 stuck high

    recirc_cdc_tx_sched_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    recirc_cdc_tx_sched #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk1     (clk1),
        .rst_clk1 (rst_clk1),
        .bus      (bus)
    );

    always #7 clk1 = ~clk1;
    // Half-ns offset keeps clk2 edges off every clk1 edge.
    initial begin
        #0.5;
        forever #3 clk2 = ~clk2;
    end

    always @(posedge clk2) ack_sh <= {ack_sh[1:0], bus.cdc_en};
    assign bus.cdc_ack_async = (ack_mode == 0) ? ack_sh[2] : (ack_mode == 2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk1);
    endtask

    task automatic set_lane(input int i, input logic [DATA_W-1:0] v);
        bus.req_data[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic wait_gnt(input string tag);
        int n = 0;
        do begin
            @(negedge clk1);
            n++;
        end while (bus.gnt == '0 && n < 60);
        chk({tag, "_gnt_seen"}, 32'(bus.gnt != '0), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk1);
            n++;
        end
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    // Grant monitor: every grant must match the head of the scoreboard.
    always @(negedge clk1) begin
        if (!rst_clk1 && bus.gnt != '0) begin
            exp_t e;
            chk("gnt_onehot", 32'($countones(bus.gnt)), 32'd1);
            chk("gnt_while_busy", 32'(prev_busy), 32'd0);
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_gnt observed=%0h expected=none", bus.gnt);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("gnt_vec", 32'(bus.gnt), 32'(4'b0001 << e.id));
                chk("cdc_id", 32'(bus.cdc_id), 32'(e.id));
                chk("cdc_data", 32'(bus.cdc_data), 32'(e.data));
            end
        end
        prev_busy = bus.busy;
    end

    initial begin
        int n, m;
        bit any_g, any_e;
        logic [DATA_W-1:0] rr_val [NUM_REQ];
        rr_val = '{8'h3C, 8'h5A, 8'h96, 8'hC3};

        rst_clk1     = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.err_clr  = 1'b0;
        cyc(2);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_data", 32'(bus.cdc_data), 32'd0);
        chk("rst_id", 32'(bus.cdc_id), 32'd0);
        chk("rst_en", 32'(bus.cdc_en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.timeout_err), 32'd0);
        rst_clk1 = 1'b0;
        cyc(2);

        // Round robin from rr_ptr=0 with all requests held.
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, rr_val[i]);
        for (int k = 0; k < 6; k++) sb.push_back({ID_W'(k % NUM_REQ), rr_val[k % NUM_REQ]});
        bus.req = 4'b1111;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk1);
            #1;
            n++;
        end
        bus.req = '0;
        chk("rr_all_granted", 32'(sb.size()), 32'd0);
        wait_idle("rr");

        // Single transfer from requester 2.
        set_lane(2, 8'hA5);
        sb.push_back({2'd2, 8'hA5});
        bus.req = 4'b0100;
        wait_gnt("single");
        chk("single_gnt", 32'(bus.gnt), 32'h4);
        bus.req = '0;
        cyc(1);
        chk("single_gnt_pulse", 32'(bus.gnt), 32'd0);
        chk("single_en_after_gnt", 32'(bus.cdc_en), 32'd1);
        n = 0;
        while (!bus.cdc_ack_async && n < 20) begin
            @(negedge clk1);
            n++;
        end
        m = 0;
        while (bus.cdc_en && m < 20) begin
            @(negedge clk1);
            m++;
        end
        chk("single_en_fall_lag", 32'(m >= 2 && m <= 3), 32'd1);
        wait_idle("single");
        chk("single_hold_data", 32'(bus.cdc_data), 32'hA5);
        chk("single_hold_id", 32'(bus.cdc_id), 32'd2);

        // Timeout with ack stuck low: rr_ptr is 3, requester 0 still wins by wrap.
        ack_mode = 1;
        set_lane(0, 8'h11);
        sb.push_back({2'd0, 8'h11});
        bus.req = 4'b0001;
        wait_gnt("to1");
        bus.req = '0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk1);
            if (bus.cdc_en) n++;
            else if (n > 0) break;
        end
        chk("to1_en_cycles", 32'(n), 32'd16);
        chk("to1_err", 32'(bus.timeout_err), 32'd1);
        chk("to1_busy", 32'(bus.busy), 32'd0);
        bus.err_clr = 1'b1;
        cyc(1);
        bus.err_clr = 1'b0;
        chk("to1_err_cleared", 32'(bus.timeout_err), 32'd0);

        // Next request is granted, and err_clr collides with its timeout.
        set_lane(1, 8'h22);
        sb.push_back({2'd1, 8'h22});
        bus.req = 4'b0010;
        wait_gnt("to2");
        bus.req = '0;
        cyc(16);
        chk("to2_en_last", 32'(bus.cdc_en), 32'd1);
        bus.err_clr = 1'b1;
        cyc(1);
        bus.err_clr = 1'b0;
        chk("to2_set_wins", 32'(bus.timeout_err), 32'd1);
        chk("to2_en_off", 32'(bus.cdc_en), 32'd0);
        bus.err_clr = 1'b1;
        cyc(1);
        bus.err_clr = 1'b0;
        chk("to2_clear", 32'(bus.timeout_err), 32'd0);

        // Stuck-high ack blocks grants; release gives grant 3 edges later.
        ack_mode = 2;
        cyc(4);
        set_lane(0, 8'h33);
        bus.req = 4'b0001;
        any_g = 1'b0;
        any_e = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk1);
            if (bus.gnt != '0) any_g = 1'b1;
            if (bus.cdc_en) any_e = 1'b1;
        end
        chk("stuck_no_gnt", 32'(any_g), 32'd0);
        chk("stuck_no_en", 32'(any_e), 32'd0);
        sb.push_back({2'd0, 8'h33});
        ack_mode = 0;
        n = 0;
        do begin
            @(negedge clk1);
            n++;
        end while (bus.gnt == '0 && n < 20);
        chk("stuck_release_lat", 32'(n), 32'd3);
        bus.req = '0;
        wait_idle("stuck");

        // Reset while in REQ, then rr_ptr must be back at 0.
        set_lane(1, 8'h44);
        sb.push_back({2'd1, 8'h44});
        bus.req = 4'b0010;
        wait_gnt("rst");
        bus.req = '0;
        cyc(1);
        chk("rst_in_req_en", 32'(bus.cdc_en), 32'd1);
        #3 rst_clk1 = 1'b1;
        #1;
        chk("rst_mid_en", 32'(bus.cdc_en), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_data", 32'(bus.cdc_data), 32'd0);
        #1 rst_clk1 = 1'b0;
        set_lane(3, 8'h55);
        sb.push_back({2'd1, 8'h44});
        sb.push_back({2'd3, 8'h55});
        @(negedge clk1);
        bus.req = 4'b1010;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk1);
            #1;
            n++;
        end
        bus.req = '0;
        chk("rst_after_grants", 32'(sb.size()), 32'd0);
        wait_idle("end");
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
